blake_g_inverse_piped: RTL and testbench
========================================

// Module: blake_g_inverse_piped
// PURPOSE
//  Pipelined inverse of the BLAKE-256 G mixing function: given G outputs (a',b',c',d')
//  and the two pre-XORed message words, recovers the G inputs (a,b,c,d).
//  Used as a self-check/readback path behind the max-piped G core: G output -> this block -> compare.
//  Fully pipelined, one G-inversion accepted per clock, valid/ready flow control.
//  Optional tag travels alongside the data.
// PARAMETERS
//  W      32  word width (rotation amounts below are for W=32)
//  ROT_A  16  first forward rotr amount on d
//  ROT_B  12  first forward rotr amount on b
//  ROT_C   8  second forward rotr amount on d
//  ROT_D   7  second forward rotr amount on b
//  TAG_W   8  width of sideband tag carried with each item
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rstn       in   1      synchronous active-low reset
//  in_valid   in   1      input item valid
//  in_ready   out  1      block can accept input this cycle
//  a_in,b_in,c_in,d_in  in  W  G outputs a',b',c',d'
//  msg_i      in   W      first message term (m[s(2i)] ^ const[s(2i+1)])
//  msg_ip     in   W      second message term (m[s(2i+1)] ^ const[s(2i)])
//  tag_in     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  a_out,b_out,c_out,d_out  out  W  recovered G inputs a,b,c,d
//  tag_out    out  TAG_W  tag of the item on the output
// BEHAVIOUR
//  Reset (rstn=0 at posedge): all 4 stage valid bits <= 0; out_valid=0.
//    All data/tag regs <= 0, so a_out..d_out, tag_out = 0.
//  Advance: en = !out_valid | out_ready; in_ready = en (combinational).
//  When en: every stage shifts one place; stage1 valid <= in_valid.
//  When !en: all stages hold, including data and valid bits.
//  Bubbles are not collapsed.
//  Latency: exactly 4 enabled cycles from an accepted input to out_valid with its result.
//  Throughput: 1 item/cycle when out_ready=1.
//  Msg/tag: msg_ip carried to S2; msg_i and tag carried to S4, in lockstep with their item.
//  Math, all mod 2^W, rotl = rotate left:
//    S1: b1 = rotl(b',ROT_D) ^ c'
//        c1 = c' - d'
//        d1 = rotl(d',ROT_C) ^ a'
//        a' registered
//    S2: a1 = a' - b1 - msg_ip
//        b1, c1, d1 registered
//    S3: b = rotl(b1,ROT_B) ^ c1
//        c = c1 - d1
//        d = rotl(d1,ROT_A) ^ a1
//        a1 registered
//    S4: a = a1 - b - msg_i
//        b, c, d registered; outputs driven directly from S4 regs
//  Wrap-around: subtractions wrap silently, no borrow/overflow flag.
//  Output stability: while out_valid & !out_ready, outputs and tag_out stay stable.
//  Simultaneous in_valid & full stall: input is not accepted (in_ready=0) and
//    must be held by the source.
//  Reset mid-operation: all in-flight items are discarded; first result after release
//    needs 4 cycles from a new accept.
//  Data regs of invalid stages may hold stale values; only valid-qualified outputs matter.
// TESTING
//  1. Known vector, msg_i=msg_ip=0, out_ready=1.
//     In: a'=0x00000011 b'=0x20220202 c'=0x11010100 d'=0x11000100.
//     Out after 4 clk: a=1 b=0 c=0 d=0.
//  2. All-zero inputs and msgs -> all-zero outputs.
//     Apply rstn=0 for 2 cycles first: all outputs 0, out_valid=0, in_ready=1.
//  3. Round-trip: 10k random (a,b,c,d,msg_i,msg_ip) through the forward G core, then this block.
//     Outputs must equal the originals; tags must return in order.
//  4. Backpressure: stream 8 items with out_ready toggling 1,0,0,1...
//     No loss or duplication; outputs stable while stalled; in_ready==out_ready whenever out_valid=1.
//  5. Reset mid-stream: 3 items in flight, pulse rstn=0 for 1 cycle.
//     out_valid=0 next cycle; no old item ever emerges.
//  6. Wrap: a'=0, msgs=0xFFFFFFFF, random b',c',d' -> matches reference model mod 2^32.

Source files
------------

// File: rtl/blake_g_inverse_piped.sv
// rtl/blake_g_inverse_piped.sv - four-stage pipelined inverse of the BLAKE-256 G function
//
// Recovers the G inputs (a,b,c,d) from the G outputs (a',b',c',d') and the two
// pre-XORed message terms. One item per clock, valid/ready handshake, with a
// sideband tag carried in lockstep with its item.
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   in_valid / in_ready           input handshake
//   a_in, b_in, c_in, d_in        G outputs a',b',c',d'
//   msg_i, msg_ip                 first / second message terms
//   tag_in                        sideband tag
//   out_valid / out_ready         output handshake
//   a_out, b_out, c_out, d_out    recovered G inputs a,b,c,d
//   tag_out                       tag of the item on the output
module blake_g_inverse_piped #(
  parameter int W     = 32,
  parameter int ROT_A = 16,
  parameter int ROT_B = 12,
  parameter int ROT_C = 8,
  parameter int ROT_D = 7,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic [W-1:0]     c_in,
  input  logic [W-1:0]     d_in,
  input  logic [W-1:0]     msg_i,
  input  logic [W-1:0]     msg_ip,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [W-1:0]     c_out,
  output logic [W-1:0]     d_out,
  output logic [TAG_W-1:0] tag_out
);

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
    return (x << n) | (x >> (W - n));
  endfunction

  // The whole pipe advances as one unit; a stalled output freezes every stage,
  // so bubbles stay where they are.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: undo the second half-round on b, c, d.
  logic             v1;
  logic [W-1:0]     a1_r, b1_r, c1_r, d1_r, mi1_r, mip1_r;
  logic [TAG_W-1:0] tag1_r;

  // Stage 2: undo the second addition into a.
  logic             v2;
  logic [W-1:0]     a2_r, b2_r, c2_r, d2_r, mi2_r;
  logic [TAG_W-1:0] tag2_r;

  // Stage 3: undo the first half-round on b, c, d.
  logic             v3;
  logic [W-1:0]     a3_r, b3_r, c3_r, d3_r, mi3_r;
  logic [TAG_W-1:0] tag3_r;

  // Stage 4: undo the first addition into a; drives the outputs directly.
  logic             v4;
  logic [W-1:0]     a4_r, b4_r, c4_r, d4_r;
  logic [TAG_W-1:0] tag4_r;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      a1_r <= '0; b1_r <= '0; c1_r <= '0; d1_r <= '0; mi1_r <= '0; mip1_r <= '0; tag1_r <= '0;
      a2_r <= '0; b2_r <= '0; c2_r <= '0; d2_r <= '0; mi2_r <= '0; tag2_r <= '0;
      a3_r <= '0; b3_r <= '0; c3_r <= '0; d3_r <= '0; mi3_r <= '0; tag3_r <= '0;
      a4_r <= '0; b4_r <= '0; c4_r <= '0; d4_r <= '0; tag4_r <= '0;
    end else if (en) begin
      v1     <= in_valid;
      a1_r   <= a_in;
      b1_r   <= rotl(b_in, ROT_D) ^ c_in;
      c1_r   <= c_in - d_in;
      d1_r   <= rotl(d_in, ROT_C) ^ a_in;
      mi1_r  <= msg_i;
      mip1_r <= msg_ip;
      tag1_r <= tag_in;

      v2     <= v1;
      a2_r   <= a1_r - b1_r - mip1_r;
      b2_r   <= b1_r;
      c2_r   <= c1_r;
      d2_r   <= d1_r;
      mi2_r  <= mi1_r;
      tag2_r <= tag1_r;

      v3     <= v2;
      a3_r   <= a2_r;
      b3_r   <= rotl(b2_r, ROT_B) ^ c2_r;
      c3_r   <= c2_r - d2_r;
      d3_r   <= rotl(d2_r, ROT_A) ^ a2_r;
      mi3_r  <= mi2_r;
      tag3_r <= tag2_r;

      v4     <= v3;
      a4_r   <= a3_r - b3_r - mi3_r;
      b4_r   <= b3_r;
      c4_r   <= c3_r;
      d4_r   <= d3_r;
      tag4_r <= tag3_r;
    end
  end

  assign out_valid = v4;
  assign a_out     = a4_r;
  assign b_out     = b4_r;
  assign c_out     = c4_r;
  assign d_out     = d4_r;
  assign tag_out   = tag4_r;

endmodule

// File: tb/tb_blake_g_inverse_piped.sv
// tb/tb_blake_g_inverse_piped.sv - scoreboard bench for blake_g_inverse_piped
module tb_blake_g_inverse_piped;

  localparam int W     = 32;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic [W-1:0]     msg_i = '0, msg_ip = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     a_out, b_out, c_out, d_out;
  logic [TAG_W-1:0] tag_out;

  blake_g_inverse_piped dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .msg_i(msg_i), .msg_ip(msg_ip), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]     a, b, c, d;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0, 2: random
  int   ready_phase = 0;
  logic [TAG_W-1:0] next_tag = '0;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
    return (x << n) | (x >> (W - n));
  endfunction

  // Forward BLAKE-256 G: the block under test must undo exactly this.
  function automatic logic [4*W-1:0] g_fwd(input logic [W-1:0] a, b, c, d, mi, mip);
    a = a + b + mi;  d = rotr(d ^ a, 16); c = c + d; b = rotr(b ^ c, 12);
    a = a + b + mip; d = rotr(d ^ a, 8);  c = c + d; b = rotr(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Direct algebraic inverse, used where no originals exist (wrap test).
  function automatic logic [4*W-1:0] g_inv(input logic [W-1:0] a, b, c, d, mi, mip);
    b = rotl(b, 7) ^ c;  c = c - d; d = rotl(d, 8) ^ a;  a = a - b - mip;
    b = rotl(b, 12) ^ c; c = c - d; d = rotl(d, 16) ^ a; a = a - b - mi;
    return {a, b, c, d};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (ready_phase == 0); ready_phase = (ready_phase + 1) % 3; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Present one item and hold it until accepted; expectation pushed on accept.
  task automatic send(input logic [W-1:0] a, b, c, d, mi, mip, input exp_t e);
    bit done = 0;
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; d_in = d; msg_i = mi; msg_ip = mip;
    tag_in = e.tag; in_valid = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) begin
      #1;
      if (in_ready && rstn) begin
        sb.push_back(e);
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_roundtrip(input logic [W-1:0] a, b, c, d, mi, mip);
    logic [4*W-1:0] f;
    exp_t e;
    f = g_fwd(a, b, c, d, mi, mip);
    e = '{a: a, b: b, c: c, d: d, tag: next_tag};
    next_tag++;
    send(f[4*W-1:3*W], f[3*W-1:2*W], f[2*W-1:W], f[W-1:0], mi, mip, e);
  endtask

  // Monitor: samples between the driver's updates and the next active edge.
  logic             held_valid = 1'b0;
  logic [W-1:0]     ha, hb, hc, hd;
  logic [TAG_W-1:0] ht;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rstn) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_valid", W'(out_valid), W'(1));
        check("stall_a", a_out, ha); check("stall_b", b_out, hb);
        check("stall_c", c_out, hc); check("stall_d", d_out, hd);
        check("stall_tag", W'(tag_out), W'(ht));
      end
      held_valid = 1'b0;
      if (out_valid) begin
        check("in_ready_eq_out_ready", W'(in_ready), W'(out_ready));
        if (!out_ready) begin
          held_valid = 1'b1;
          ha = a_out; hb = b_out; hc = c_out; hd = d_out; ht = tag_out;
        end else if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got tag 0x%02h expected no output", tag_out);
        end else begin
          e = sb.pop_front();
          check("a", a_out, e.a); check("b", b_out, e.b);
          check("c", c_out, e.c); check("d", d_out, e.d);
          check("tag", W'(tag_out), W'(e.tag));
        end
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int   lat;
    exp_t e;
    logic [W-1:0] rb, rc, rd;
    logic [4*W-1:0] inv;

    // Test 2a: reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_a", a_out, '0); check("rst_b", b_out, '0);
    check("rst_c", c_out, '0); check("rst_d", d_out, '0);
    check("rst_tag", W'(tag_out), W'(0));
    rstn = 1'b1;

    // Test 1: known vector, 4-cycle latency
    e = '{a: 32'd1, b: '0, c: '0, d: '0, tag: 8'hA5};
    send(32'h00000011, 32'h20220202, 32'h11010100, 32'h11000100, '0, '0, e);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk); #3;
      if (out_valid) lat = n;
    end
    check("latency", W'(lat), W'(4));
    wait_drain();

    // Test 2b: all-zero item
    e = '{a: '0, b: '0, c: '0, d: '0, tag: 8'h00};
    send('0, '0, '0, '0, '0, '0, e);
    wait_drain();

    // Test 4: backpressure pattern 1,0,0
    ready_mode = 1;
    for (int i = 0; i < 8; i++)
      send_roundtrip($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    wait_drain();

    // Test 5: reset with 3 items in flight
    ready_mode = 0;
    for (int i = 0; i < 3; i++)
      send_roundtrip($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    @(negedge clk);
    rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    #3 check("reset_flush_valid", W'(out_valid), W'(0));
    send_roundtrip(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 32'h5, 32'h6);
    wait_drain();

    // Test 6: wrap-around, a'=0, msgs all ones
    ready_mode = 2;
    for (int i = 0; i < 16; i++) begin
      rb = $urandom; rc = $urandom; rd = $urandom;
      inv = g_inv('0, rb, rc, rd, '1, '1);
      e = '{a: inv[4*W-1:3*W], b: inv[3*W-1:2*W], c: inv[2*W-1:W], d: inv[W-1:0], tag: next_tag};
      next_tag++;
      send('0, rb, rc, rd, '1, '1, e);
    end
    wait_drain();

    // Test 3: random round-trip through the forward G
    for (int i = 0; i < 10000; i++)
      send_roundtrip($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
